// File: rtl/disp_ctrl_pkg.sv
// Shared types and constants for the display/time-set controller:
// mode encoding, cursor positions, digit limits and the BCD edit helpers.
package disp_ctrl_pkg;

  typedef enum logic [1:0] {
    SHOW_TIME  = 2'd0,
    SHOW_ALARM = 2'd1,
    SET_TIME   = 2'd2,
    SET_ALARM  = 2'd3
  } state_e;

  typedef logic [2:0] cursor_t;

  localparam cursor_t DIG_HT = 3'd4;
  localparam cursor_t DIG_HU = 3'd3;
  localparam cursor_t DIG_MT = 3'd2;
  localparam cursor_t DIG_MU = 3'd1;

  localparam logic [3:0] HT_MAX       = 4'd2;
  localparam logic [3:0] HU_MAX       = 4'd9;
  localparam logic [3:0] MT_MAX       = 4'd5;
  localparam logic [3:0] MU_MAX       = 4'd9;
  localparam logic [3:0] HU_MAX_AT_20 = 4'd3;

  localparam int unsigned BLINK_MS_DEF   = 250;
  localparam int unsigned TIMEOUT_MS_DEF = 10000;

  typedef struct packed {
    logic [3:0] hr_t;
    logic [3:0] hr_u;
    logic [3:0] min_t;
    logic [3:0] min_u;
  } bcd_time_t;

  function automatic logic [3:0] bcd_wrap_inc(input logic [3:0] val, input logic [3:0] max);
    return (val >= max) ? 4'd0 : val + 4'd1;
  endfunction

  // Bumping hour tens onto 2 pulls hour units down so the result is never past 23.
  function automatic bcd_time_t edit_inc(input bcd_time_t t, input cursor_t cur);
    bcd_time_t r;
    r = t;
    case (cur)
      DIG_HT: begin
        r.hr_t = bcd_wrap_inc(t.hr_t, HT_MAX);
        if ((r.hr_t == HT_MAX) && (t.hr_u > HU_MAX_AT_20)) r.hr_u = HU_MAX_AT_20;
      end
      DIG_HU: r.hr_u = bcd_wrap_inc(t.hr_u, (t.hr_t == HT_MAX) ? HU_MAX_AT_20 : HU_MAX);
      DIG_MT: r.min_t = bcd_wrap_inc(t.min_t, MT_MAX);
      DIG_MU: r.min_u = bcd_wrap_inc(t.min_u, MU_MAX);
      default: r = t;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/disp_ctrl_if.sv
// Button, live-time and display bundle between the controller and its neighbours.
// master drives buttons/live time; slave is the controller side.
interface disp_ctrl_if;
  logic       tick_ms;
  logic       btn_mode;
  logic       btn_sel;
  logic       btn_inc;
  logic [3:0] hr_t;
  logic [3:0] hr_u;
  logic [3:0] min_t;
  logic [3:0] min_u;
  logic [3:0] numcount4_out;
  logic [3:0] numcount3_out;
  logic [3:0] numcount2_out;
  logic [3:0] numcount1_out;
  logic [3:0] digit_blank;
  logic [3:0] set_hr_t;
  logic [3:0] set_hr_u;
  logic [3:0] set_min_t;
  logic [3:0] set_min_u;
  logic       time_load;
  logic [3:0] al_hr_t;
  logic [3:0] al_hr_u;
  logic [3:0] al_min_t;
  logic [3:0] al_min_u;
  logic [1:0] mode_out;

  modport master (
    output tick_ms, btn_mode, btn_sel, btn_inc, hr_t, hr_u, min_t, min_u,
    input  numcount4_out, numcount3_out, numcount2_out, numcount1_out, digit_blank,
    input  set_hr_t, set_hr_u, set_min_t, set_min_u, time_load,
    input  al_hr_t, al_hr_u, al_min_t, al_min_u, mode_out
  );

  modport slave (
    input  tick_ms, btn_mode, btn_sel, btn_inc, hr_t, hr_u, min_t, min_u,
    output numcount4_out, numcount3_out, numcount2_out, numcount1_out, digit_blank,
    output set_hr_t, set_hr_u, set_min_t, set_min_u, time_load,
    output al_hr_t, al_hr_u, al_min_t, al_min_u, mode_out
  );
endinterface

// File: rtl/disp_ctrl_blink_gen.sv
// Cursor blink phase: toggles every BLINK_MS ticks, restart forces it visible.
// The next phase is exported so the caller can register it alongside its own outputs.
module blink_gen
  import disp_ctrl_pkg::*;
#(
  parameter int unsigned BLINK_MS = BLINK_MS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic restart_i,
  output logic phaseNext_o
);

  localparam int CW = $clog2(BLINK_MS + 1);

  logic [CW-1:0] tickCnt_q, tickCnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    tickCnt_d = tickCnt_q;
    phase_d   = phase_q;
    if (restart_i) begin
      tickCnt_d = '0;
      phase_d   = 1'b1;
    end else if (tick_i) begin
      if (tickCnt_q == CW'(BLINK_MS - 1)) begin
        tickCnt_d = '0;
        phase_d   = ~phase_q;
      end else begin
        tickCnt_d = tickCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tickCnt_q <= '0;
      phase_q   <= 1'b1;
    end else begin
      tickCnt_q <= tickCnt_d;
      phase_q   <= phase_d;
    end
  end

  assign phaseNext_o = phase_d;

endmodule

// File: rtl/disp_ctrl.sv
// Mode FSM, digit editor and alarm register for the four-digit clock display.
// Every output is registered from next-state values so it moves with the state.
module disp_ctrl
  import disp_ctrl_pkg::*;
#(
  parameter int unsigned BLINK_MS   = BLINK_MS_DEF,
  parameter int unsigned TIMEOUT_MS = TIMEOUT_MS_DEF
) (
  input logic         clk,
  input logic         rst,
  disp_ctrl_if.slave  bus
);

  localparam int IW = $clog2(TIMEOUT_MS + 1);

  state_e        state_q, state_d;
  cursor_t       cursor_q, cursor_d;
  bcd_time_t     edit_q, edit_d;
  bcd_time_t     alarm_q, alarm_d;
  logic [IW-1:0] idleCnt_q, idleCnt_d;
  bcd_time_t     disp_q, disp_d;
  bcd_time_t     setOut_q, setOut_d;
  logic [3:0]    blank_q, blank_d;
  logic          load_q, load_d;

  bcd_time_t live;
  logic      anyBtn;
  logic      inSet;
  logic      timeout;
  logic      phaseNext;

  assign live    = {bus.hr_t, bus.hr_u, bus.min_t, bus.min_u};
  assign anyBtn  = bus.btn_mode | bus.btn_sel | bus.btn_inc;
  assign inSet   = (state_q == SET_TIME) || (state_q == SET_ALARM);
  assign timeout = bus.tick_ms && (state_q != SHOW_TIME) && (idleCnt_q == IW'(TIMEOUT_MS - 1));

  blink_gen #(.BLINK_MS(BLINK_MS)) u_blink (
    .clk         (clk),
    .rst         (rst),
    .tick_i      (bus.tick_ms),
    .restart_i   (anyBtn),
    .phaseNext_o (phaseNext)
  );

  // Buttons are mutually exclusive by priority; a timeout only acts on a button-free cycle.
  always_comb begin
    state_d   = state_q;
    cursor_d  = cursor_q;
    edit_d    = edit_q;
    alarm_d   = alarm_q;
    load_d    = 1'b0;
    idleCnt_d = idleCnt_q;

    if (bus.btn_mode) begin
      case (state_q)
        SHOW_TIME:  state_d = SHOW_ALARM;
        SHOW_ALARM: begin
          state_d  = SET_TIME;
          edit_d   = live;
          cursor_d = DIG_HT;
        end
        SET_TIME: begin
          state_d  = SET_ALARM;
          load_d   = 1'b1;
          edit_d   = alarm_q;
          cursor_d = DIG_HT;
        end
        SET_ALARM: begin
          state_d = SHOW_TIME;
          alarm_d = edit_q;
        end
        default: state_d = SHOW_TIME;
      endcase
    end else if (bus.btn_sel) begin
      if (inSet) cursor_d = (cursor_q == DIG_MU) ? DIG_HT : cursor_q - 3'd1;
    end else if (bus.btn_inc) begin
      if (inSet) edit_d = edit_inc(edit_q, cursor_q);
    end else if (timeout) begin
      state_d = SHOW_TIME;
    end

    if (anyBtn || (state_q == SHOW_TIME) || timeout) idleCnt_d = '0;
    else if (bus.tick_ms) idleCnt_d = idleCnt_q + 1'b1;
  end

  // The edit buffer is reloaded with the alarm on the commit edge, so set_* holds the old copy then.
  always_comb begin
    case (state_d)
      SHOW_TIME:  disp_d = live;
      SHOW_ALARM: disp_d = alarm_d;
      default:    disp_d = edit_d;
    endcase
    setOut_d = load_d ? edit_q : edit_d;
    blank_d  = '0;
    if (((state_d == SET_TIME) || (state_d == SET_ALARM)) && !phaseNext)
      blank_d = 4'b0001 << (cursor_d - 3'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SHOW_TIME;
      cursor_q  <= DIG_HT;
      edit_q    <= '0;
      alarm_q   <= '0;
      idleCnt_q <= '0;
      disp_q    <= '0;
      setOut_q  <= '0;
      blank_q   <= '0;
      load_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cursor_q  <= cursor_d;
      edit_q    <= edit_d;
      alarm_q   <= alarm_d;
      idleCnt_q <= idleCnt_d;
      disp_q    <= disp_d;
      setOut_q  <= setOut_d;
      blank_q   <= blank_d;
      load_q    <= load_d;
    end
  end

  assign bus.numcount4_out = disp_q.hr_t;
  assign bus.numcount3_out = disp_q.hr_u;
  assign bus.numcount2_out = disp_q.min_t;
  assign bus.numcount1_out = disp_q.min_u;
  assign bus.digit_blank   = blank_q;
  assign bus.set_hr_t      = setOut_q.hr_t;
  assign bus.set_hr_u      = setOut_q.hr_u;
  assign bus.set_min_t     = setOut_q.min_t;
  assign bus.set_min_u     = setOut_q.min_u;
  assign bus.time_load     = load_q;
  assign bus.al_hr_t       = alarm_q.hr_t;
  assign bus.al_hr_u       = alarm_q.hr_u;
  assign bus.al_min_t      = alarm_q.min_t;
  assign bus.al_min_u      = alarm_q.min_u;
  assign bus.mode_out      = state_q;

endmodule

// File: tb/tb_disp_ctrl.sv
// Bench for disp_ctrl: a vector table plus hand sequences for blink, timeout and reset,
// then random buttons/ticks against a digit-array model of the clock-setting rules.
module tb_disp_ctrl;

  localparam int BLINK   = 250;
  localparam int TIMEOUT = 10000;

  logic clk;
  logic rst;
  disp_ctrl_if bus ();

  disp_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: digits indexed by display position (4 = hour tens ... 1 = minute units).
  int mMode, mCursor, mIdle, mBlinkCnt;
  bit mPhase;
  int mEdit[1:4];
  int mAlarm[1:4];
  logic [15:0] eDisp, eSet, eAl;
  logic [3:0]  eBlank;
  logic        eLoad;
  logic [1:0]  eMode;

  typedef struct {
    logic        m, s, i;
    logic [1:0]  expMode;
    logic [15:0] expDisp;
    logic [15:0] expSet;
    logic [15:0] expAl;
    logic        expLoad;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [15:0] pack4(input int d4, input int d3, input int d2, input int d1);
    return {4'(d4), 4'(d3), 4'(d2), 4'(d1)};
  endfunction

  function automatic vec_t mk(input logic m, input logic s, input logic i, input logic [1:0] md,
                              input logic [15:0] dsp, input logic [15:0] st,
                              input logic [15:0] al, input logic ld);
    vec_t v;
    v.m = m; v.s = s; v.i = i; v.expMode = md; v.expDisp = dsp;
    v.expSet = st; v.expAl = al; v.expLoad = ld;
    return v;
  endfunction

  function automatic logic [15:0] dutDisp();
    return {bus.numcount4_out, bus.numcount3_out, bus.numcount2_out, bus.numcount1_out};
  endfunction

  function automatic logic [15:0] dutSet();
    return {bus.set_hr_t, bus.set_hr_u, bus.set_min_t, bus.set_min_u};
  endfunction

  function automatic logic [15:0] dutAl();
    return {bus.al_hr_t, bus.al_hr_u, bus.al_min_t, bus.al_min_u};
  endfunction

  task automatic compare(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bumpDigit();
    case (mCursor)
      4: begin
        mEdit[4] = (mEdit[4] + 1) % 3;
        if (mEdit[4] == 2 && mEdit[3] > 3) mEdit[3] = 3;
      end
      3: mEdit[3] = (mEdit[3] + 1) % ((mEdit[4] == 2) ? 4 : 10);
      2: mEdit[2] = (mEdit[2] + 1) % 6;
      default: mEdit[1] = (mEdit[1] + 1) % 10;
    endcase
  endtask

  task automatic modelStep();
    int live[1:4];
    int saved[1:4];
    int oldMode;
    bit anyBtn;
    live[4] = int'(bus.hr_t);  live[3] = int'(bus.hr_u);
    live[2] = int'(bus.min_t); live[1] = int'(bus.min_u);
    anyBtn = bus.btn_mode | bus.btn_sel | bus.btn_inc;
    if (rst) begin
      mMode = 0; mCursor = 4; mIdle = 0; mBlinkCnt = 0; mPhase = 1'b1;
      mEdit = '{default: 0}; mAlarm = '{default: 0};
      eDisp = '0; eSet = '0; eAl = '0; eBlank = '0; eLoad = 1'b0; eMode = 2'd0;
      return;
    end
    eLoad = 1'b0;
    saved = mEdit;
    oldMode = mMode;
    if (bus.btn_mode) begin
      if (mMode == 2) eLoad = 1'b1;
      if (mMode == 3) mAlarm = mEdit;
      mMode = (mMode + 1) % 4;
      if (mMode == 2) mEdit = live;
      if (mMode == 3) mEdit = mAlarm;
      if (mMode >= 2) mCursor = 4;
    end else if (bus.btn_sel) begin
      if (mMode >= 2) mCursor = (mCursor == 1) ? 4 : mCursor - 1;
    end else if (bus.btn_inc) begin
      if (mMode >= 2) bumpDigit();
    end
    if (anyBtn || oldMode == 0) mIdle = 0;
    else if (bus.tick_ms) begin
      mIdle++;
      if (mIdle == TIMEOUT) begin
        mIdle = 0;
        mMode = 0;
      end
    end
    if (anyBtn) begin
      mBlinkCnt = 0;
      mPhase = 1'b1;
    end else if (bus.tick_ms) begin
      mBlinkCnt++;
      if (mBlinkCnt == BLINK) begin
        mBlinkCnt = 0;
        mPhase = !mPhase;
      end
    end
    if (mMode == 0)      eDisp = pack4(live[4], live[3], live[2], live[1]);
    else if (mMode == 1) eDisp = pack4(mAlarm[4], mAlarm[3], mAlarm[2], mAlarm[1]);
    else                 eDisp = pack4(mEdit[4], mEdit[3], mEdit[2], mEdit[1]);
    eBlank = (mMode >= 2 && !mPhase) ? 4'(1 << (mCursor - 1)) : 4'd0;
    eSet = eLoad ? pack4(saved[4], saved[3], saved[2], saved[1])
                 : pack4(mEdit[4], mEdit[3], mEdit[2], mEdit[1]);
    eAl = pack4(mAlarm[4], mAlarm[3], mAlarm[2], mAlarm[1]);
    eMode = 2'(mMode);
  endtask

  task automatic applyStimulus(input logic m, input logic s, input logic i, input logic tk);
    bus.btn_mode = m;
    bus.btn_sel  = s;
    bus.btn_inc  = i;
    bus.tick_ms  = tk;
  endtask

  task automatic setLive(input int ht, input int hu, input int mt, input int mu);
    bus.hr_t = 4'(ht); bus.hr_u = 4'(hu); bus.min_t = 4'(mt); bus.min_u = 4'(mu);
  endtask

  task automatic checkOutput();
    compare("model_mode",  {14'd0, bus.mode_out}, {14'd0, eMode});
    compare("model_disp",  dutDisp(), eDisp);
    compare("model_blank", {12'd0, bus.digit_blank}, {12'd0, eBlank});
    compare("model_load",  {15'd0, bus.time_load}, {15'd0, eLoad});
    compare("model_set",   dutSet(), eSet);
    compare("model_alarm", dutAl(), eAl);
  endtask

  task automatic cycle();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic press(input logic m, input logic s, input logic i);
    applyStimulus(m, s, i, 1'b0);
    cycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int ht, hu;
    int loadSeen;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    setLive(1, 2, 3, 4);

    // Reset state, then live time one cycle after release.
    cycle();
    cycle();
    compare("rst_disp", dutDisp(), 16'h0000);
    compare("rst_mode", {14'd0, bus.mode_out}, 16'd0);
    compare("rst_load", {15'd0, bus.time_load}, 16'd0);
    compare("rst_alarm", dutAl(), 16'h0000);
    rst = 1'b0;
    cycle();
    compare("live_disp", dutDisp(), 16'h1234);
    compare("live_blank", {12'd0, bus.digit_blank}, 16'd0);

    vecs.push_back(mk(0,0,0, 2'd0, 16'h1234, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(1,0,0, 2'd1, 16'h0000, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(1,0,0, 2'd2, 16'h1234, 16'h1234, 16'h0000, 0));
    vecs.push_back(mk(0,0,1, 2'd2, 16'h2234, 16'h2234, 16'h0000, 0));
    vecs.push_back(mk(0,0,1, 2'd2, 16'h0234, 16'h0234, 16'h0000, 0));
    vecs.push_back(mk(0,0,1, 2'd2, 16'h1234, 16'h1234, 16'h0000, 0));
    vecs.push_back(mk(0,1,0, 2'd2, 16'h1234, 16'h1234, 16'h0000, 0));
    vecs.push_back(mk(0,0,1, 2'd2, 16'h1334, 16'h1334, 16'h0000, 0));
    vecs.push_back(mk(0,0,1, 2'd2, 16'h1434, 16'h1434, 16'h0000, 0));
    vecs.push_back(mk(0,0,1, 2'd2, 16'h1534, 16'h1534, 16'h0000, 0));
    vecs.push_back(mk(0,0,1, 2'd2, 16'h1634, 16'h1634, 16'h0000, 0));
    vecs.push_back(mk(0,0,1, 2'd2, 16'h1734, 16'h1734, 16'h0000, 0));
    vecs.push_back(mk(0,0,1, 2'd2, 16'h1834, 16'h1834, 16'h0000, 0));
    vecs.push_back(mk(0,0,1, 2'd2, 16'h1934, 16'h1934, 16'h0000, 0));
    vecs.push_back(mk(0,1,0, 2'd2, 16'h1934, 16'h1934, 16'h0000, 0));
    vecs.push_back(mk(0,1,0, 2'd2, 16'h1934, 16'h1934, 16'h0000, 0));
    vecs.push_back(mk(0,1,0, 2'd2, 16'h1934, 16'h1934, 16'h0000, 0));
    vecs.push_back(mk(0,0,1, 2'd2, 16'h2334, 16'h2334, 16'h0000, 0));
    vecs.push_back(mk(0,0,1, 2'd2, 16'h0334, 16'h0334, 16'h0000, 0));
    vecs.push_back(mk(0,0,1, 2'd2, 16'h1334, 16'h1334, 16'h0000, 0));
    vecs.push_back(mk(0,1,0, 2'd2, 16'h1334, 16'h1334, 16'h0000, 0));
    vecs.push_back(mk(0,0,1, 2'd2, 16'h1434, 16'h1434, 16'h0000, 0));
    vecs.push_back(mk(1,0,0, 2'd3, 16'h0000, 16'h1434, 16'h0000, 1));
    vecs.push_back(mk(0,0,0, 2'd3, 16'h0000, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(0,1,0, 2'd3, 16'h0000, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(0,1,0, 2'd3, 16'h0000, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(0,0,1, 2'd3, 16'h0010, 16'h0010, 16'h0000, 0));
    vecs.push_back(mk(0,0,1, 2'd3, 16'h0020, 16'h0020, 16'h0000, 0));
    vecs.push_back(mk(0,0,1, 2'd3, 16'h0030, 16'h0030, 16'h0000, 0));
    vecs.push_back(mk(0,0,1, 2'd3, 16'h0040, 16'h0040, 16'h0000, 0));
    vecs.push_back(mk(0,0,1, 2'd3, 16'h0050, 16'h0050, 16'h0000, 0));
    vecs.push_back(mk(0,0,1, 2'd3, 16'h0000, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(1,0,0, 2'd0, 16'h1234, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(1,0,0, 2'd1, 16'h0000, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(1,0,0, 2'd2, 16'h1234, 16'h1234, 16'h0000, 0));
    vecs.push_back(mk(1,0,1, 2'd3, 16'h0000, 16'h1234, 16'h0000, 1));
    vecs.push_back(mk(0,0,1, 2'd3, 16'h1000, 16'h1000, 16'h0000, 0));
    vecs.push_back(mk(0,1,1, 2'd3, 16'h1000, 16'h1000, 16'h0000, 0));
    vecs.push_back(mk(0,0,1, 2'd3, 16'h1100, 16'h1100, 16'h0000, 0));
    vecs.push_back(mk(1,0,0, 2'd0, 16'h1234, 16'h1100, 16'h1100, 0));
    vecs.push_back(mk(1,0,0, 2'd1, 16'h1100, 16'h1100, 16'h1100, 0));
    vecs.push_back(mk(0,1,0, 2'd1, 16'h1100, 16'h1100, 16'h1100, 0));
    vecs.push_back(mk(0,0,1, 2'd1, 16'h1100, 16'h1100, 16'h1100, 0));

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].m, vecs[k].s, vecs[k].i, 1'b0);
      cycle();
      compare($sformatf("vec%0d_mode", k), {14'd0, bus.mode_out}, {14'd0, vecs[k].expMode});
      compare($sformatf("vec%0d_disp", k), dutDisp(), vecs[k].expDisp);
      compare($sformatf("vec%0d_set", k), dutSet(), vecs[k].expSet);
      compare($sformatf("vec%0d_alarm", k), dutAl(), vecs[k].expAl);
      compare($sformatf("vec%0d_load", k), {15'd0, bus.time_load}, {15'd0, vecs[k].expLoad});
      compare($sformatf("vec%0d_blank", k), {12'd0, bus.digit_blank}, 16'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Enter SET_TIME, then idle: blink half-periods and auto-return without a load.
    press(1'b1, 1'b0, 1'b0);
    compare("tmo_enter_mode", {14'd0, bus.mode_out}, 16'd2);
    loadSeen = 0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      cycle();
      if (bus.time_load) loadSeen++;
      if (k == BLINK - 1)     compare("blink_on_end",   {12'd0, bus.digit_blank}, 16'h0000);
      if (k == BLINK)         compare("blink_off",      {12'd0, bus.digit_blank}, 16'h0008);
      if (k == 2 * BLINK - 1) compare("blink_off_end",  {12'd0, bus.digit_blank}, 16'h0008);
      if (k == 2 * BLINK)     compare("blink_on_again", {12'd0, bus.digit_blank}, 16'h0000);
      if (k == TIMEOUT - 1)   compare("tmo_before",     {14'd0, bus.mode_out}, 16'd2);
    end
    compare("tmo_mode", {14'd0, bus.mode_out}, 16'd0);
    compare("tmo_no_load", 16'(loadSeen), 16'd0);
    compare("tmo_alarm_kept", dutAl(), 16'h1100);

    // A button on the timeout cycle wins and restarts the idle count.
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    for (int k = 1; k < TIMEOUT; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      cycle();
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    cycle();
    compare("tie_mode", {14'd0, bus.mode_out}, 16'd2);
    compare("tie_blank", {12'd0, bus.digit_blank}, 16'd0);
    for (int k = 1; k <= TIMEOUT; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      cycle();
      if (k == TIMEOUT - 1) compare("tie_restart", {14'd0, bus.mode_out}, 16'd2);
    end
    compare("tie_tmo_mode", {14'd0, bus.mode_out}, 16'd0);

    // Reset in the middle of an alarm edit.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    compare("seqc_show_alarm", dutDisp(), 16'h1100);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    compare("seqc_edit", dutDisp(), 16'h2100);
    rst = 1'b1;
    cycle();
    compare("seqc_rst_alarm", dutAl(), 16'h0000);
    compare("seqc_rst_mode", {14'd0, bus.mode_out}, 16'd0);
    compare("seqc_rst_load", {15'd0, bus.time_load}, 16'd0);
    compare("seqc_rst_set", dutSet(), 16'h0000);
    rst = 1'b0;
    cycle();
    compare("seqc_after_disp", dutDisp(), 16'h1234);

    // Random bursts of buttons and live-time changes separated by idle tick gaps.
    for (int seg = 0; seg < 20; seg++) begin
      int gap;
      for (int c = 0; c < 40; c++) begin
        if ($urandom_range(0, 7) == 0) begin
          ht = $urandom_range(0, 2);
          hu = (ht == 2) ? $urandom_range(0, 3) : $urandom_range(0, 9);
          setLive(ht, hu, $urandom_range(0, 5), $urandom_range(0, 9));
        end
        rst = ($urandom_range(0, 199) == 0);
        applyStimulus($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0);
        cycle();
      end
      rst = 1'b0;
      gap = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 10, TIMEOUT + 10)
                                        : $urandom_range(0, 700);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      for (int c = 0; c < gap; c++) cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_ctrl.md
# disp_ctrl

Display and time-set controller for the four-digit clock display. Selects what the digit scanner shows: live time, alarm time, or an edit buffer. Runs the mode state machine driven by three pre-debounced buttons and owns the alarm register. In set modes it edits digits with a blinking cursor and issues a one-cycle load to the timekeeper. Its four digit outputs feed the scanner's numcount inputs directly.

## Interface
- BLINK_MS, 250: tick_ms strobes per blink half-period.
- TIMEOUT_MS, 10000: idle tick_ms strobes before auto-return to SHOW_TIME.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick_ms  in  1  one-cycle strobe, 1 kHz.
- btn_mode, btn_sel, btn_inc  in  1 each  debounced single-cycle press pulses.
- hr_t, hr_u, min_t, min_u  in  4 each  live BCD time from the timekeeper.
- numcount4_out..numcount1_out  out  4 each  BCD digits to the scanner; 4 = hour tens … 1 = minute units.
- digit_blank  out  4  bit k-1 set = blank digit k.
- set_hr_t, set_hr_u, set_min_t, set_min_u  out  4 each  edit buffer.
- time_load  out  1  one-cycle pulse: timekeeper loads the set_* values.
- al_hr_t, al_hr_u, al_min_t, al_min_u  out  4 each  committed alarm time.
- mode_out  out  2  current state encoding.

## Operation
- States: SHOW_TIME=0, SHOW_ALARM=1, SET_TIME=2, SET_ALARM=3.
- btn_mode cycles through SHOW_TIME→SHOW_ALARM→SET_TIME→SET_ALARM→SHOW_TIME.
- Entering SET_TIME: the edit buffer copies the live time.
- Entering SET_ALARM: the edit buffer copies the alarm register.
- Entering either set state resets the cursor to 4 (hour tens).
- Leaving SET_TIME via btn_mode: time_load pulses and the edit buffer is valid on set_* in that cycle.
- Leaving SET_ALARM via btn_mode: the alarm register is written from the edit buffer.
- btn_sel advances the cursor 4→3→2→1→4. It is ignored outside the set states.
- btn_inc increments the cursor digit, wrapping to 0 past its maximum:
  - hour tens: 0..2
  - hour units: 0..9, or 0..3 when hour tens = 2
  - minute tens: 0..5
  - minute units: 0..9
- When hour tens becomes 2 with hour units >3, hour units clamps to 3 in the same update.
- Display source:
  - SHOW_TIME: live time.
  - SHOW_ALARM: alarm register.
  - Set states: edit buffer.
- digit_blank: in set states, the cursor digit is blanked while the blink phase is off. Otherwise all zeros.
- Blink phase toggles every BLINK_MS tick_ms strobes. It is forced on and the counter is cleared on any button press, so the digit is visible immediately after an edit.
- Idle timeout: counts tick_ms strobes in any state except SHOW_TIME, and clears on any button. At TIMEOUT_MS the block returns to SHOW_TIME without committing: no time_load, alarm unchanged.
- Simultaneous events, priority btn_mode > btn_sel > btn_inc. Only the highest-priority button acts.
- A button in the same cycle as the timeout wins, and the timeout is discarded.

## Timing
- All outputs are registered.
- A button pulse at edge N changes state, cursor and digit at edge N+1. numcount*_out and digit_blank reflect the change at N+1.
- In SHOW_TIME, a live time change propagates to numcount*_out with 1 cycle latency.
- time_load is high for exactly 1 cycle, coincident with the state change to SET_ALARM.
- Reset values:
  - state SHOW_TIME, mode_out 0, cursor 4
  - edit buffer and alarm 0000
  - numcount*_out 0, digit_blank 0, time_load 0
  - blink phase on; blink and idle counters 0
- rst mid-edit discards the edit buffer, issues no time_load, and clears the alarm register.

## Structure
- disp_ctrl_pkg holds:
  - the state encoding
  - cursor constants DIG_HT=4, DIG_HU=3, DIG_MT=2, DIG_MU=1
  - per-digit maximum constants 2/9/5/9 and HU_MAX_AT_20=3
  - the BLINK_MS and TIMEOUT_MS defaults
- Sub-module blink_gen: tick_ms counter with restart input that produces the blink phase.
- The mode FSM, edit buffer, alarm register and output mux stay in disp_ctrl.

## Test plan
- Reset, live time 12:34 → numcount4..1 = 1,2,3,4 one cycle after release; digit_blank=0; mode_out=0.
- mode×2 with live 12:34, then inc×2 on hour tens → hour tens wraps 1→2→0. Then inc on 2 gives 23:34 path: set hr 1,9 → inc hour tens → 2,3 clamp.
- SET_TIME: sel, inc×3 (14:34), mode → time_load single pulse with set_* = 1,4,3,4; mode_out=3.
- SET_ALARM from 00:00: sel×2, inc×6 → minute tens wraps to 0. Then mode → alarm = 00:00 committed, mode_out=0.
- SET_TIME idle TIMEOUT_MS ticks → mode_out=0, time_load never asserted. Blink observed with the cursor digit blanked for BLINK_MS ticks on / BLINK_MS ticks off.
- btn_mode and btn_inc in the same cycle in SET_TIME → only the state advances and the digit is unchanged. rst during SET_ALARM → alarm 0000, state 0.
